timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 19 +
 rtl/timer_ctrl.sv | 151 +++++++++++++++
 tb/tb_timer_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Register bus between a host and timer_ctrl.
// Single-cycle read/write strobes and a registered read-data return.
interface timer_ctrl_if;
   logic       wr_en;
   logic       rd_en;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;

   modport master (
      output wr_en, rd_en, addr, wdata,
      input  rdata
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata,
      output rdata
   );
endinterface

// File: rtl/timer_ctrl.sv
// Timer control block: TDR/TCR/TSR registers, prescaler and load/run FSM.
// Every counter-facing output comes straight from a flop.
module timer_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   timer_ctrl_if.slave  bus,
   input  logic         i_overflow,
   input  logic         i_underflow,
   output logic [7:0]   o_start_counter,
   output logic         o_load,
   output logic         o_up_down,
   output logic         o_enable,
   output logic         o_clk_ena,
   output logic         o_clr_overflow,
   output logic         o_clr_underflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_tdr;
   logic       r_up;
   logic       r_en_bit;
   logic [2:0] r_cks;
   logic [7:0] r_div;
   logic [7:0] r_rdata;
   logic       r_load;
   logic       r_enable;
   logic       r_clk_ena;
   logic       r_clr_ov;
   logic       r_clr_un;

   logic       w_tcr_wr;
   logic       w_ld_req;
   logic       w_en_bit;
   logic [2:0] w_cks;
   logic       w_load_nxt;
   logic       w_en_nxt;
   logic       w_div_clr;
   logic [7:0] w_div_nxt;
   logic       w_tick;
   logic [7:0] w_rd_val;

   always_comb begin
      w_tcr_wr = bus.wr_en && (bus.addr == 2'd1);
      w_ld_req = w_tcr_wr && bus.wdata[7];
      w_en_bit = w_tcr_wr ? bus.wdata[4] : r_en_bit;
      w_cks    = w_tcr_wr ? bus.wdata[2:0] : r_cks;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_ld_req)
               w_state_nxt = S_LOAD;
            else if (w_tcr_wr && bus.wdata[4])
               w_state_nxt = S_RUN;
         end
         S_LOAD: begin
            if (w_ld_req)     w_state_nxt = S_LOAD;
            else if (w_en_bit) w_state_nxt = S_RUN;
            else              w_state_nxt = S_IDLE;
         end
         S_RUN: begin
            if (w_ld_req)
               w_state_nxt = S_LOAD;
            else if (w_tcr_wr && !bus.wdata[4])
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_load_nxt = (w_state_nxt == S_LOAD);
      w_en_nxt   = (w_state_nxt == S_RUN) ||
                   (w_load_nxt && w_en_bit);
   end

   // Divider restarts on entry to LOAD or on a CKS change
   always_comb begin
      w_div_clr = w_load_nxt ||
                  (w_tcr_wr && (bus.wdata[2:0] != r_cks));
      w_div_nxt = w_div_clr ? 8'd0 : r_div + 8'd1;
      w_tick    = w_en_nxt && w_div_nxt[w_cks] && !r_div[w_cks];
   end

   always_comb begin
      w_rd_val = 8'h00;
      unique case (1'b1)
         (bus.addr == 2'd0): w_rd_val = r_tdr;
         (bus.addr == 2'd1): w_rd_val = {2'b00, r_up, r_en_bit,
                                         1'b0, r_cks};
         (bus.addr == 2'd2): w_rd_val = {6'd0, i_underflow,
                                         i_overflow};
         (bus.addr == 2'd3): w_rd_val = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tdr     <= 8'h00;
         r_up      <= 1'b0;
         r_en_bit  <= 1'b0;
         r_cks     <= 3'd0;
         r_div     <= 8'h00;
         r_rdata   <= 8'h00;
         r_load    <= 1'b0;
         r_enable  <= 1'b0;
         r_clk_ena <= 1'b0;
         r_clr_ov  <= 1'b0;
         r_clr_un  <= 1'b0;
      end else begin
         if (bus.wr_en && (bus.addr == 2'd0))
            r_tdr <= bus.wdata;
         if (w_tcr_wr) begin
            r_up     <= bus.wdata[5];
            r_en_bit <= bus.wdata[4];
            r_cks    <= bus.wdata[2:0];
         end
         if (bus.rd_en)
            r_rdata <= w_rd_val;
         r_div     <= w_div_nxt;
         r_load    <= w_load_nxt;
         r_enable  <= w_en_nxt;
         r_clk_ena <= w_tick;
         r_clr_ov  <= bus.wr_en && (bus.addr == 2'd2) &&
                      bus.wdata[0];
         r_clr_un  <= bus.wr_en && (bus.addr == 2'd2) &&
                      bus.wdata[1];
      end
   end

   assign bus.rdata       = r_rdata;
   assign o_start_counter = r_tdr;
   assign o_load          = r_load;
   assign o_up_down       = r_up;
   assign o_enable        = r_enable;
   assign o_clk_ena       = r_clk_ena;
   assign o_clr_overflow  = r_clr_ov;
   assign o_clr_underflow = r_clr_un;

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized bench for timer_ctrl against a cycle-level reference model.
// Directed scenarios first, then random register traffic.
module tb_timer_ctrl;

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;

   logic       clk;
   logic       rst_n;
   logic       r_ov;
   logic       r_un;
   logic [7:0] w_start;
   logic       w_load;
   logic       w_up;
   logic       w_enable;
   logic       w_clk_ena;
   logic       w_clr_ov;
   logic       w_clr_un;

   int n_err;
   int n_chk;

   int         m_mode;
   int         m_n;
   logic [7:0] m_tdr;
   logic       m_up;
   logic       m_enb;
   logic [2:0] m_cks;
   logic [7:0] m_rdata;
   logic       e_load;
   logic       e_enable;
   logic       e_tick;
   logic       e_clr_ov;
   logic       e_clr_un;

   timer_ctrl_if bus ();

   timer_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus.slave),
      .i_overflow      (r_ov),
      .i_underflow     (r_un),
      .o_start_counter (w_start),
      .o_load          (w_load),
      .o_up_down       (w_up),
      .o_enable        (w_enable),
      .o_clk_ena       (w_clk_ena),
      .o_clr_overflow  (w_clr_ov),
      .o_clr_underflow (w_clr_un)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_n      = 0;
      m_tdr    = 8'h00;
      m_up     = 1'b0;
      m_enb    = 1'b0;
      m_cks    = 3'd0;
      m_rdata  = 8'h00;
      e_load   = 1'b0;
      e_enable = 1'b0;
      e_tick   = 1'b0;
      e_clr_ov = 1'b0;
      e_clr_un = 1'b0;
   endtask

   // One clock edge of the reference: inputs as sampled on that edge
   task automatic model_edge(input logic wr, input logic rd,
                             input logic [1:0] a,
                             input logic [7:0] d);
      logic tw;
      logic clr;
      int   c;
      if (rd) begin
         case (a)
            2'd0:    m_rdata = m_tdr;
            2'd1:    m_rdata = {2'b00, m_up, m_enb, 1'b0, m_cks};
            2'd2:    m_rdata = {6'd0, r_un, r_ov};
            default: m_rdata = 8'h00;
         endcase
      end
      tw  = wr && (a == 2'd1);
      clr = tw && (d[2:0] != m_cks);
      if (tw) begin
         m_up  = d[5];
         m_enb = d[4];
         m_cks = d[2:0];
      end
      if (tw && d[7])
         m_mode = M_LOAD;
      else if (m_mode == M_LOAD)
         m_mode = m_enb ? M_RUN : M_IDLE;
      else if (tw)
         m_mode = d[4] ? M_RUN : M_IDLE;
      if (m_mode == M_LOAD)
         clr = 1'b1;
      m_n = clr ? 0 : m_n + 1;
      c = int'(m_cks);
      e_load   = (m_mode == M_LOAD);
      e_enable = (m_mode == M_RUN) || (e_load && m_enb);
      e_tick   = e_enable &&
                 ((m_n % (1 << (c + 1))) == (1 << c));
      if (wr && (a == 2'd0))
         m_tdr = d;
      e_clr_ov = wr && (a == 2'd2) && d[0];
      e_clr_un = wr && (a == 2'd2) && d[1];
   endtask

   task automatic compare_all();
      chk("load",    {7'd0, w_load},    {7'd0, e_load});
      chk("enable",  {7'd0, w_enable},  {7'd0, e_enable});
      chk("clk_ena", {7'd0, w_clk_ena}, {7'd0, e_tick});
      chk("up_down", {7'd0, w_up},      {7'd0, m_up});
      chk("start",   w_start,           m_tdr);
      chk("clr_ov",  {7'd0, w_clr_ov},  {7'd0, e_clr_ov});
      chk("clr_un",  {7'd0, w_clr_un},  {7'd0, e_clr_un});
      chk("rdata",   bus.rdata,         m_rdata);
   endtask

   task automatic step(input logic wr, input logic rd,
                       input logic [1:0] a,
                       input logic [7:0] d);
      bus.wr_en = wr;
      bus.rd_en = rd;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      model_edge(wr, rd, a, d);
      #1;
      compare_all();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 2'd0, 8'h00);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int first;
   int ticks;

   initial begin
      n_err     = 0;
      n_chk     = 0;
      r_ov      = 1'b0;
      r_un      = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.addr  = 2'd0;
      bus.wdata = 8'h00;
      rst_n     = 1'b1;
      #2;
      do_reset();

      step(1'b1, 1'b0, 2'd0, 8'h00);
      step(1'b1, 1'b0, 2'd1, 8'h93);
      chk("r33_load", {7'd0, w_load}, 8'd1);
      chk("r33_en", {7'd0, w_enable}, 8'd1);
      first = -1;
      ticks = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, 1'b0, 2'd0, 8'h00);
         if (i == 1)
            chk("r33_ld_drop", {7'd0, w_load}, 8'd0);
         if (w_clk_ena) begin
            ticks++;
            if (first < 0) first = i;
         end
      end
      chk("r33_first", 8'(first), 8'd8);
      chk("r33_ticks", 8'(ticks), 8'd3);

      step(1'b1, 1'b0, 2'd0, 8'd50);
      chk("r34_start", w_start, 8'd50);
      chk("r34_noload", {7'd0, w_load}, 8'd0);
      idle(9);

      step(1'b1, 1'b0, 2'd1, 8'h12);
      first = -1;
      ticks = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b0, 2'd0, 8'h00);
         if (w_clk_ena) begin
            ticks++;
            if (first < 0) first = i;
         end
      end
      chk("r35_first", 8'(first), 8'd4);
      chk("r35_ticks", 8'(ticks), 8'd3);

      r_ov = 1'b1;
      step(1'b1, 1'b0, 2'd2, 8'h01);
      chk("r36_clr_ov", {7'd0, w_clr_ov}, 8'd1);
      chk("r36_clr_un", {7'd0, w_clr_un}, 8'd0);
      step(1'b0, 1'b1, 2'd2, 8'h00);
      chk("r36_clr_drop", {7'd0, w_clr_ov}, 8'd0);
      chk("r36_tsr", bus.rdata, 8'h01);
      r_ov = 1'b0;

      step(1'b1, 1'b0, 2'd1, 8'h02);
      chk("r37_en_off", {7'd0, w_enable}, 8'd0);
      idle(5);
      step(1'b1, 1'b0, 2'd1, 8'h80);
      chk("r37_load", {7'd0, w_load}, 8'd1);
      idle(1);
      chk("r37_idle_ld", {7'd0, w_load}, 8'd0);
      chk("r37_idle_en", {7'd0, w_enable}, 8'd0);
      idle(6);

      step(1'b1, 1'b0, 2'd3, 8'hFF);
      step(1'b0, 1'b1, 2'd3, 8'h00);
      chk("rsvd_rd", bus.rdata, 8'h00);
      step(1'b1, 1'b0, 2'd1, 8'h7F);
      step(1'b0, 1'b1, 2'd1, 8'h00);
      chk("tcr_mask", bus.rdata, 8'h37);

      step(1'b1, 1'b0, 2'd1, 8'h93);
      chk("r38_load", {7'd0, w_load}, 8'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("r38_async", {7'd0, w_load}, 8'd0);
      compare_all();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(6);

      for (int i = 0; i < 3000; i++) begin
         logic       wr;
         logic       rd;
         logic [1:0] a;
         logic [7:0] d;
         wr   = ($urandom_range(0, 5) == 0);
         rd   = ($urandom_range(0, 1) == 0);
         a    = 2'($urandom_range(0, 3));
         d    = 8'($urandom);
         r_ov = ($urandom_range(0, 3) == 0);
         r_un = ($urandom_range(0, 3) == 0);
         step(wr, rd, a, d);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
